// File: rtl/wb_timer_pkg.sv
// Shared register map, widths and helpers for the wb_timer CLINT-style timer.
package wb_timer_pkg;

  localparam int unsigned REG_W = 64;

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

  localparam logic [REG_W-1:0] MTIMECMP_RST = '1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  // Word decode; the byte offset within the word is ignored.
  function automatic reg_sel_e decode_off(input logic [15:0] off);
    reg_sel_e r;
    unique case ({off[15:2], 2'b00})
      OFF_MSIP:    r = SEL_MSIP;
      OFF_CMP_LO:  r = SEL_CMP_LO;
      OFF_CMP_HI:  r = SEL_CMP_HI;
      OFF_TIME_LO: r = SEL_TIME_LO;
      OFF_TIME_HI: r = SEL_TIME_HI;
      default:     r = SEL_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_counter.sv
// Prescaler plus free-running 64-bit mtime with byte-lane write-load of either half.
module wb_timer_counter
  import wb_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld_lo,
  input  logic             i_ld_hi,
  input  logic [31:0]      i_ld_dat,
  input  logic [3:0]       i_ld_sel,
  output logic             o_tick,
  output logic [REG_W-1:0] o_mtime
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0]      r_presc;
  logic [REG_W-1:0] r_mtime;
  logic             w_wrap;

  assign w_wrap = (r_presc == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // A load wins over the tick; the untouched half holds and no carry is applied.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtime <= '0;
    end else if (i_ld_lo) begin
      r_mtime[31:0] <= merge_lanes(r_mtime[31:0], i_ld_dat, i_ld_sel);
    end else if (i_ld_hi) begin
      r_mtime[63:32] <= merge_lanes(r_mtime[63:32], i_ld_dat, i_ld_sel);
    end else if (w_wrap) begin
      r_mtime <= r_mtime + REG_W'(1);
    end
  end

  assign o_tick  = w_wrap;
  assign o_mtime = r_mtime;

endmodule

// File: rtl/wb_timer.sv
// Wishbone machine timer (msip / mtimecmp / mtime). Define WB_TIMER_ERR_EN to
// terminate unmapped offsets with wbs_err_o instead of a zero-data ack.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  logic             w_req;
  logic             w_start;
  logic             w_ack_nxt;
  logic             w_commit;
  logic             w_ld_lo;
  logic             w_ld_hi;
  logic             w_tick;
  reg_sel_e         w_sel_reg;
  logic [31:0]      w_rdata;
  logic [REG_W-1:0] w_mtime;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_wr_pend;
  reg_sel_e         r_wr_reg;
  logic [31:0]      r_wr_dat;
  logic [3:0]       r_wr_sel;
  logic [REG_W-1:0] r_cmp;
  logic             r_msip;
  logic             r_mtip;
  logic             r_chg;

  assign w_req     = wbs_cyc_i & wbs_stb_i & (wbs_addr_i[31:16] == BASE_ADDR[31:16]);
  assign w_sel_reg = decode_off(wbs_addr_i[15:0]);

`ifdef WB_TIMER_ERR_EN
  logic r_err;
  logic w_err_nxt;

  assign w_start   = w_req & ~r_ack & ~r_err;
  assign w_ack_nxt = w_start & (w_sel_reg != SEL_NONE);
  assign w_err_nxt = w_start & (w_sel_reg == SEL_NONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= w_err_nxt;
  end

  assign wbs_err_o = r_err;
`else
  assign w_start   = w_req & ~r_ack;
  assign w_ack_nxt = w_start;
  assign wbs_err_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    unique case (w_sel_reg)
      SEL_MSIP:    w_rdata[0] = r_msip;
      SEL_CMP_LO:  w_rdata    = r_cmp[31:0];
      SEL_CMP_HI:  w_rdata    = r_cmp[63:32];
      SEL_TIME_LO: w_rdata    = w_mtime[31:0];
      SEL_TIME_HI: w_rdata    = w_mtime[63:32];
      default:     w_rdata    = '0;
    endcase
  end

  // Write target is captured with the request and committed at the end of the ack cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_wr_pend <= 1'b0;
      r_wr_reg  <= SEL_NONE;
      r_wr_dat  <= '0;
      r_wr_sel  <= '0;
    end else begin
      r_ack     <= w_ack_nxt;
      r_dat     <= (w_ack_nxt & ~wbs_we_i) ? w_rdata : '0;
      r_wr_pend <= w_ack_nxt & wbs_we_i;
      if (w_start) begin
        r_wr_reg <= w_sel_reg;
        r_wr_dat <= wbs_dat_i;
        r_wr_sel <= wbs_sel_i;
      end
    end
  end

  assign w_commit = r_wr_pend & (|r_wr_sel);
  assign w_ld_lo  = w_commit & (r_wr_reg == SEL_TIME_LO);
  assign w_ld_hi  = w_commit & (r_wr_reg == SEL_TIME_HI);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cmp  <= MTIMECMP_RST;
      r_msip <= 1'b0;
    end else if (w_commit) begin
      unique case (r_wr_reg)
        SEL_CMP_LO: r_cmp[31:0]  <= merge_lanes(r_cmp[31:0], r_wr_dat, r_wr_sel);
        SEL_CMP_HI: r_cmp[63:32] <= merge_lanes(r_cmp[63:32], r_wr_dat, r_wr_sel);
        SEL_MSIP:   if (r_wr_sel[0]) r_msip <= r_wr_dat[0];
        default:    ;
      endcase
    end
  end

  // Operands only move on a tick or a committed write, so the compare is
  // re-evaluated exactly in the cycle after one of those.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chg  <= 1'b0;
      r_mtip <= 1'b0;
    end else begin
      r_chg <= w_tick | w_commit;
      if (r_chg) r_mtip <= (w_mtime >= r_cmp);
    end
  end

  wb_timer_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_counter (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_ld_lo  (w_ld_lo),
    .i_ld_hi  (w_ld_hi),
    .i_ld_dat (r_wr_dat),
    .i_ld_sel (r_wr_sel),
    .o_tick   (w_tick),
    .o_mtime  (w_mtime)
  );

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign xint_mtip_o = r_mtip;
  assign xint_msip_o = r_msip;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer with a cycle-level reference model checked every cycle.
module tb_wb_timer;

`ifdef WB_TIMER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat, dat_o;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic        ack, err, mtip, msip;

  int n_cmp = 0;
  int n_bad = 0;

  wb_timer #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wbs_addr_i  (addr),
    .wbs_dat_i   (wdat),
    .wbs_sel_i   (sel),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_dat_o   (dat_o),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .xint_mtip_o (mtip),
    .xint_msip_o (msip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_ack, m_err, m_mtip;
  logic [31:0] m_dat;
  logic        p_we;
  int          p_reg;
  logic [31:0] p_dat;
  logic [3:0]  p_sel;

  function automatic int reg_of(input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000: return 1;
      16'h4000: return 2;
      16'h4004: return 3;
      16'hBFF8: return 4;
      16'hBFFC: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  initial begin
    forever begin
      logic        req, n_ack, n_err, n_mtip;
      logic [31:0] n_dat;
      logic [63:0] nt;
      int          r;
      @(negedge clk);
      if (rst) begin
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_dat", dat_o, 0);
        check("rst_mtip", mtip, 0);
        check("rst_msip", msip, 0);
        m_time = '0; m_cmp = '1; m_msip = 0;
        m_ack = 0; m_err = 0; m_mtip = 0; m_dat = '0;
        p_we = 0; p_reg = 0; p_dat = '0; p_sel = '0;
      end else begin
        check("cyc_ack", ack, m_ack);
        check("cyc_err", err, m_err);
        check("cyc_dat", dat_o, m_dat);
        check("cyc_mtip", mtip, m_mtip);
        check("cyc_msip", msip, m_msip);
        // outcome of the coming rising edge
        req = cyc && stb && (addr[31:16] == BASE[31:16]);
        r = reg_of(addr[15:0]);
        n_ack = 0; n_err = 0; n_dat = '0;
        if (req && !m_ack && !m_err) begin
          if (r == 0 && ERR_EN) n_err = 1;
          else begin
            n_ack = 1;
            if (!we) case (r)
              1: n_dat = {31'b0, m_msip};
              2: n_dat = m_cmp[31:0];
              3: n_dat = m_cmp[63:32];
              4: n_dat = m_time[31:0];
              5: n_dat = m_time[63:32];
              default: n_dat = '0;
            endcase
          end
        end
        n_mtip = (m_time >= m_cmp);
        nt = m_time + 64'd1;
        if (m_ack && p_we && p_sel != 4'b0) case (p_reg)
          1: if (p_sel[0]) m_msip = p_dat[0];
          2: m_cmp[31:0]  = lanes(m_cmp[31:0], p_dat, p_sel);
          3: m_cmp[63:32] = lanes(m_cmp[63:32], p_dat, p_sel);
          4: nt = {m_time[63:32], lanes(m_time[31:0], p_dat, p_sel)};
          5: nt = {lanes(m_time[63:32], p_dat, p_sel), m_time[31:0]};
          default: ;
        endcase
        if (n_ack) begin p_we = we; p_reg = r; p_dat = wdat; p_sel = sel; end
        m_time = nt; m_ack = n_ack; m_err = n_err; m_dat = n_dat; m_mtip = n_mtip;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    cyc = 0; stb = 0; we = 0; sel = '0; addr = '0; wdat = '0;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    addr = a; we = w; wdat = d; sel = s; cyc = 1; stb = 1;
    got_ack = 0; got_err = 0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = dat_o;
        break;
      end
    end
    idle();
    if (!got_ack && !got_err) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout addr %h: got no termination, required one", a);
    end
  endtask

  task automatic rd32(input logic [15:0] off, output logic [31:0] d);
    logic a, e;
    bus(BASE | {16'h0, off}, 1'b0, '0, 4'hF, d, a, e);
  endtask

  task automatic wr32(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] x;
    logic a, e;
    bus(BASE | {16'h0, off}, 1'b1, d, s, x, a, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        ga, ge;
    int          cnt;
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ack, 0);
    check("reset_dat", dat_o, 0);
    check("reset_mtip", mtip, 0);
    rst = 0;

    // read mtime lo roughly ten cycles after release
    repeat (9) @(posedge clk);
    bus(BASE | 32'hBFF8, 1'b0, '0, 4'hF, d, ga, ge);
    check_range("mtime_after_reset", d, 10, 12);
    check("mtime_read_ack", ga, 1);
    check("mtime_read_err", ge, 0);
    check("mtime_read_mtip", mtip, 0);
    rd32(16'h4004, d);
    check("cmp_hi_reset", d, 32'hFFFF_FFFF);

    // compare match raises mtip, restoring all ones drops it
    wr32(16'hBFF8, 32'h0, 4'hF);
    wr32(16'h4004, 32'h0, 4'hF);
    wr32(16'h4000, 32'd20, 4'hF);
    for (int i = 0; i < 60 && !mtip; i++) begin @(posedge clk); #1; end
    check("mtip_rise", mtip, 1);
    rd32(16'hBFF8, d);
    check_range("mtime_at_rise", d, 21, 24);
    wr32(16'h4000, 32'hFFFF_FFFF, 4'hF);
    wr32(16'h4004, 32'hFFFF_FFFF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("mtip_fall", mtip, 0);

    // mtime wraps through all ones
    wr32(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr32(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    check("mtip_before_equal", mtip, 0);
    @(posedge clk); #1;
    check("mtip_at_equal", mtip, 1);
    rd32(16'hBFF8, d);
    check_range("mtime_lo_wrapped", d, 0, 6);
    rd32(16'hBFFC, d);
    check("mtime_hi_wrapped", d, 0);

    // msip and byte lanes
    wr32(16'h0000, 32'h1, 4'b0001);
    @(posedge clk); #1;
    check("msip_set", msip, 1);
    wr32(16'h0000, 32'h0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("msip_sel0_hold", msip, 1);
    wr32(16'h0000, 32'hFFFF_FFFE, 4'hF);
    wr32(16'h0000, 32'hFFFF_FFFF, 4'hF);
    rd32(16'h0000, d);
    check("msip_readback", d, 32'h1);
    wr32(16'h0000, 32'h0, 4'b0001);
    @(posedge clk); #1;
    check("msip_clear", msip, 0);

    // held strobe: one ack every second cycle
    @(posedge clk); #1;
    addr = BASE | 32'h4000; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        cnt++;
        check("held_stb_data", dat_o, 32'hFFFF_FFFF);
      end
    end
    idle();
    check("held_stb_acks", cnt, 3);
    @(posedge clk); #1;
    check("held_stb_quiet", ack, 0);

    // unmapped offset inside window, then request outside window
    bus(BASE | 32'h0100, 1'b0, '0, 4'hF, d, ga, ge);
    check("unmapped_err", ge, ERR_EN);
    check("unmapped_ack", ga, !ERR_EN);
    check("unmapped_data", d, 0);
    @(posedge clk); #1;
    addr = 32'h0300_4000; sel = 4'hF; cyc = 1; stb = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack || err) cnt++;
    end
    idle();
    check("outside_window_terms", cnt, 0);

    // reset in the middle of a request
    @(posedge clk); #1;
    addr = BASE | 32'h4000; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    #2 rst = 1;
    @(posedge clk); #1;
    idle();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack || err) cnt++;
    end
    check("abandoned_terms", cnt, 0);
    rd32(16'h4000, d);
    check("cmp_lo_after_rst", d, 32'hFFFF_FFFF);
    rd32(16'hBFF8, d);
    check_range("mtime_after_rst", d, 4, 12);

    wr32(16'h4004, 32'h1234_5678, 4'b0010);
    rd32(16'h4004, d);
    check("cmp_hi_lane1", d, 32'hFFFF_56FF);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000; window base, decoded on addr[31:16].
REQ-002 SHALL have parameter TICK_DIV, default 1; clocks per mtime increment, legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1; single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset, asynchronous, active-high.
REQ-005 SHALL have port wbs_addr_i, input, 32; byte address.
REQ-006 SHALL have port wbs_dat_i, input, 32; write data.
REQ-007 SHALL have port wbs_sel_i, input, 4; byte lane enables.
REQ-008 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 each; Wishbone cycle, strobe, write-enable.
REQ-009 SHALL have port wbs_dat_o, output, 32; read data, valid while wbs_ack_o=1.
REQ-010 SHALL have ports wbs_ack_o and wbs_err_o, output, 1 each; termination pulses.
REQ-011 SHALL have ports xint_mtip_o and xint_msip_o, output, 1 each; timer and software interrupt requests to the core.

Function
REQ-012 SHALL map offsets (addr[15:0]): 0x0000 msip (bit 0 only, others read 0); 0x4000/0x4004 mtimecmp lo/hi; 0xBFF8/0xBFFC mtime lo/hi.
REQ-013 SHALL select when cyc&stb&(addr[31:16]==BASE_ADDR[31:16]); addr[1:0] ignored.
REQ-014 SHALL register termination: ack (or err) asserted exactly one cycle after a selected request, one cycle wide; ack <= req & ~ack & ~err, so a held stb yields one termination every second cycle.
REQ-015 SHALL apply writes in the termination cycle, per byte lane per wbs_sel_i; sel=0000 terminates with no state change.
REQ-016 SHALL return reads as register value sampled in the request cycle; wbs_dat_o 0 when not terminating.
REQ-017 SHALL run a prescaler 0..TICK_DIV-1; mtime increments by 1 when prescaler wraps; TICK_DIV=1 increments every cycle.
REQ-018 SHALL wrap mtime 64'hFFFF_FFFF_FFFF_FFFF -> 0 without flag.
REQ-019 SHALL give bus write to an mtime half priority over the increment in the same cycle; other half keeps its value, no carry applied that cycle; prescaler not reset.
REQ-020 SHALL register xint_mtip_o = (mtime >= mtimecmp), unsigned 64-bit, one cycle latency after either operand changes.
REQ-021 SHALL drive xint_msip_o directly from msip bit 0.
REQ-022 SHALL not respond to requests outside the window (no ack, no err) -- except per REQ-026.

Reset
REQ-023 SHALL, while rst_i=1 regardless of clock, force mtime=0, mtimecmp=all ones, msip=0, prescaler=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, xint_mtip_o=0, xint_msip_o=0.
REQ-024 SHALL abandon an in-flight request on reset; no termination is issued for it after release.

Configuration
REQ-025 SHALL use macro WB_TIMER_ERR_EN.
REQ-026 SHALL, with WB_TIMER_ERR_EN defined, terminate selected requests to unmapped offsets with wbs_err_o instead of ack, no state change.
REQ-027 SHALL, without WB_TIMER_ERR_EN, ack unmapped offsets with read data 0, ignore writes, tie wbs_err_o to 0.

Structure
REQ-028 SHALL place offset constants, mtimecmp reset value and register width in package wb_timer_pkg.
REQ-029 SHALL implement the prescaler plus 64-bit mtime counter as sub-module wb_timer_counter (write-load port, tick output).

Verification
REQ-030 Reset release, TICK_DIV=1, read 0xBFF8 after 10 cycles -> ack next cycle, data within 10..12, mtip=0, err=0.
REQ-031 Write mtimecmp hi=0, lo=20 with mtime below 20 -> mtip rises one cycle after mtime reaches 20; write lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> mtip falls next cycle.
REQ-032 Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> mtime reads 0 after wrap; mtip stays 0 when mtimecmp all ones until mtime equals it.
REQ-033 Write 0x0000 data 1 sel=0001 -> msip=1 one cycle after ack; sel=0000 write of 0 -> msip stays 1.
REQ-034 Hold stb 6 cycles on 0x4000 read -> exactly 3 ack pulses, alternating cycles.
REQ-035 Read offset 0x0100 -> err pulse with WB_TIMER_ERR_EN, ack with data 0 without it; assert rst_i mid-request -> no termination after release.
